// File: rtl/mod_n_serial.sv
// mod_n_serial: computes (serial MSB-first value) mod MOD over a framed
// bit stream, with a saturating bit counter and a one-cycle result pulse.
module mod_n_serial #(
  parameter int MOD   = 3,
  parameter int CNT_W = 16,
  localparam int REM_W = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic [REM_W-1:0] remainder,
  output logic             divisible,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow,
  output logic             has_result
);

  generate
    if (MOD < 2 || MOD > 255) begin : gBadMod
      $error("mod_n_serial: MOD must lie in 2..255");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [REM_W:0]   MOD_V   = MOD[REM_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [REM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic             overflow_q, overflow_d;
  logic [REM_W-1:0] remainder_q, remainder_d;
  logic             divisible_q, divisible_d;
  logic             pending_q, pending_d;
  logic             hasResult_q, hasResult_d;
  logic             consume;
  logic [REM_W:0]   accDbl;
  logic [REM_W:0]   accWrap;

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start always (re)opens a frame, finish alone closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (!start && finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy mirrors the state, bits are taken only in RUN without start.
  always_comb begin
    busy    = (state_q == RUN);
    consume = (state_q == RUN) && in_valid && !start;
  end

  // Accumulator step: 2*acc+in never exceeds 2*MOD-1, so one conditional subtract suffices.
  always_comb begin
    accDbl  = {acc_q, 1'b0} + {{REM_W{1'b0}}, in};
    accWrap = (accDbl >= MOD_V) ? (accDbl - MOD_V) : accDbl;
  end

  // Datapath next state: start clears the frame, a finish in RUN arms a one-cycle-later result.
  always_comb begin
    acc_d       = acc_q;
    bitCnt_d    = bitCnt_q;
    overflow_d  = overflow_q;
    remainder_d = remainder_q;
    divisible_d = divisible_q;
    pending_d   = 1'b0;
    hasResult_d = pending_q;
    if (start) begin
      acc_d       = '0;
      bitCnt_d    = '0;
      overflow_d  = 1'b0;
      remainder_d = '0;
      divisible_d = 1'b0;
      hasResult_d = 1'b0;
    end else begin
      if (consume) begin
        acc_d = accWrap[REM_W-1:0];
        if (bitCnt_q == CNT_MAX) overflow_d = 1'b1;
        else                     bitCnt_d   = bitCnt_q + CNT_ONE;
      end
      pending_d = (state_q == RUN) && finish;
      if (pending_q) begin
        remainder_d = acc_q;
        divisible_d = (acc_q == '0);
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      bitCnt_q    <= '0;
      overflow_q  <= 1'b0;
      remainder_q <= '0;
      divisible_q <= 1'b0;
      pending_q   <= 1'b0;
      hasResult_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      bitCnt_q    <= bitCnt_d;
      overflow_q  <= overflow_d;
      remainder_q <= remainder_d;
      divisible_q <= divisible_d;
      pending_q   <= pending_d;
      hasResult_q <= hasResult_d;
    end
  end

  assign remainder  = remainder_q;
  assign divisible  = divisible_q;
  assign bit_count  = bitCnt_q;
  assign overflow   = overflow_q;
  assign has_result = hasResult_q;

endmodule

// File: tb/tb_mod_n_serial.sv
// Testbench for mod_n_serial: three instances (MOD=3, MOD=7, MOD=5 with a
// 3-bit counter) share one stimulus stream; expectations are hand-computed.
module tb_mod_n_serial;

  logic clk = 1'b0;
  logic rst, start, finish, inValid, inBit;

  logic       busy3, div3, ovf3, hr3;
  logic [1:0] rem3;
  logic [15:0] cnt3;
  logic       busy7, div7, ovf7, hr7;
  logic [2:0] rem7;
  logic [15:0] cnt7;
  logic       busy5, div5, ovf5, hr5;
  logic [2:0] rem5;
  logic [2:0] cnt5;

  int nVec = 0;
  int nMis = 0;
  int hrCount3 = 0;
  int base;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    bit          gaps;
    int rem3; int div3;
    int rem7; int div7;
    int rem5; int div5; int cnt5; int ovf5;
  } vec_t;

  vec_t vecs[8];

  mod_n_serial #(.MOD(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(inValid), .in(inBit),
    .busy(busy3), .remainder(rem3), .divisible(div3), .bit_count(cnt3),
    .overflow(ovf3), .has_result(hr3));

  mod_n_serial #(.MOD(7), .CNT_W(16)) u7 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(inValid), .in(inBit),
    .busy(busy7), .remainder(rem7), .divisible(div7), .bit_count(cnt7),
    .overflow(ovf7), .has_result(hr7));

  mod_n_serial #(.MOD(5), .CNT_W(3)) u5 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(inValid), .in(inBit),
    .busy(busy5), .remainder(rem5), .divisible(div5), .bit_count(cnt5),
    .overflow(ovf5), .has_result(hr5));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hr3) hrCount3 <= hrCount3 + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic v, input logic b);
    @(negedge clk);
    start   = s;
    finish  = f;
    inValid = v;
    inBit   = b;
  endtask

  task automatic runFrame(input vec_t v, input int idx);
    applyStimulus(1, 0, 0, 0);
    if (v.nbits == 0) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < v.nbits; i++) begin
      if (v.gaps)
        for (int g = 0; g < (i % 4); g++) applyStimulus(0, 0, 0, ~v.bits[v.nbits-1-i]);
      applyStimulus(0, (i == v.nbits-1), 1, v.bits[v.nbits-1-i]);
    end
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d.hrEarly", idx), {hr3, hr7, hr5}, 0);
    checkOutput($sformatf("v%0d.remBefore", idx), {rem3, div3}, 0);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d.hr", idx), {hr3, hr7, hr5}, 3'b111);
    checkOutput($sformatf("v%0d.rem3", idx), rem3, v.rem3);
    checkOutput($sformatf("v%0d.div3", idx), div3, v.div3);
    checkOutput($sformatf("v%0d.cnt3", idx), cnt3, v.nbits);
    checkOutput($sformatf("v%0d.ovf3", idx), ovf3, 0);
    checkOutput($sformatf("v%0d.rem7", idx), rem7, v.rem7);
    checkOutput($sformatf("v%0d.div7", idx), div7, v.div7);
    checkOutput($sformatf("v%0d.rem5", idx), rem5, v.rem5);
    checkOutput($sformatf("v%0d.div5", idx), div5, v.div5);
    checkOutput($sformatf("v%0d.cnt5", idx), cnt5, v.cnt5);
    checkOutput($sformatf("v%0d.ovf5", idx), ovf5, v.ovf5);
    checkOutput($sformatf("v%0d.busy", idx), busy3, 0);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d.hrLate", idx), {hr3, hr7, hr5}, 0);
    checkOutput($sformatf("v%0d.rem3Held", idx), rem3, v.rem3);
  endtask

  initial begin
    //         nbits bits          gaps r3 d3 r7 d7 r5 d5 c5 o5
    vecs[0] = '{3, 16'b110,       1'b0, 0, 1, 6, 0, 1, 0, 3, 0};
    vecs[1] = '{6, 16'b101101,    1'b1, 0, 1, 3, 0, 0, 1, 6, 0};
    vecs[2] = '{0, 16'h0000,      1'b0, 0, 1, 0, 1, 0, 1, 0, 0};
    vecs[3] = '{9, 16'h01FF,      1'b0, 1, 0, 0, 1, 1, 0, 7, 1};
    vecs[4] = '{4, 16'b1011,      1'b1, 2, 0, 4, 0, 1, 0, 4, 0};
    vecs[5] = '{5, 16'b10000,     1'b0, 1, 0, 2, 0, 1, 0, 5, 0};
    vecs[6] = '{7, 16'h007F,      1'b1, 1, 0, 1, 0, 2, 0, 7, 0};
    vecs[7] = '{8, 16'h00FE,      1'b0, 2, 0, 2, 0, 4, 0, 7, 1};

    rst = 1'b1; start = 1'b1; finish = 1'b0; inValid = 1'b1; inBit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", {busy3, busy7, busy5}, 0);
    checkOutput("reset.rem", {rem3, rem7, rem5}, 0);
    checkOutput("reset.div", {div3, div7, div5}, 0);
    checkOutput("reset.cnt", cnt3 | cnt7 | {13'd0, cnt5}, 0);
    checkOutput("reset.ovf", {ovf3, ovf7, ovf5}, 0);
    checkOutput("reset.hr", {hr3, hr7, hr5}, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; inValid = 1'b0; inBit = 1'b0;

    for (int k = 0; k < 8; k++) runFrame(vecs[k], k);

    // Restart mid-frame (start with finish and a valid bit is ignored), then 1,0.
    base = hrCount3;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("restart.cnt3", cnt3, 0);
    checkOutput("restart.rem3", {rem3, div3}, 0);
    checkOutput("restart.busy", busy3, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 1, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("restart.pulses", hrCount3 - base, 1);
    checkOutput("restart.rem3", rem3, 2);
    checkOutput("restart.cnt3", cnt3, 2);
    checkOutput("restart.rem7", rem7, 2);
    checkOutput("restart.rem5", rem5, 2);

    // finish and in_valid while idle change nothing.
    base = hrCount3;
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("idle.pulses", hrCount3 - base, 0);
    checkOutput("idle.rem3", rem3, 2);
    checkOutput("idle.cnt3", cnt3, 2);
    checkOutput("idle.busy", busy3, 0);

    // start and finish together, then finish alone gives the empty-frame result.
    base = hrCount3;
    applyStimulus(1, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("sf.noPulse", hrCount3 - base, 0);
    checkOutput("sf.busy", busy3, 1);
    checkOutput("sf.remDiv", {rem3, div3}, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("empty.pulses", hrCount3 - base, 1);
    checkOutput("empty.rem3", rem3, 0);
    checkOutput("empty.div3", div3, 1);
    checkOutput("empty.cnt3", cnt3, 0);
    checkOutput("empty.busy", busy3, 0);

    // Reset mid-frame (with a simultaneous start), then finish: frame discarded.
    base = hrCount3;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; inValid = 1'b1; inBit = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; finish = 1'b1; inValid = 1'b1; inBit = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("rst.pulses", hrCount3 - base, 0);
    checkOutput("rst.busy", {busy3, busy7, busy5}, 0);
    checkOutput("rst.rem", {rem3, rem7, rem5}, 0);
    checkOutput("rst.div", {div3, div7, div5}, 0);
    checkOutput("rst.cnt", cnt3 | cnt7 | {13'd0, cnt5}, 0);
    checkOutput("rst.ovf", {ovf3, ovf7, ovf5}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
